fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
- Shares one multi-cycle float_point_add unit among N_REQ requesters using round-robin arbitration.
- Issues one operation at a time: a one-cycle op strobe with operands held, then waits for the adder's done pulse.
- Returns the result on a shared response bus tagged with the requester ID.
- Sits between producer blocks (valid/ready request ports) and the adder's iA/iB/iOp/oF/oDone interface.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2^ID_W >= N_REQ.
- TIMEOUT, 64, cycles allowed in WAIT before abort (used only with the optional feature).
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- iReqValid  in  N_REQ  per-requester request valid.
- iReqA  in  32*N_REQ  operand A; requester k uses bits [32k+31:32k].
- iReqB  in  32*N_REQ  operand B, packed the same way.
- iReqOp  in  2*N_REQ  op per requester: 01 add, 10 sub, 00/11 illegal.
- oReqReady  out  N_REQ  one-hot accept to the granted requester.
- oRspValid  out  1  response valid.
- oRspId  out  ID_W  requester ID of the response.
- oRspF  out  32  result.
- oRspErr  out  1  1 = illegal op or timeout.
- iRspReady  in  1  response consumer ready.
- oA  out  32  to adder iA.
- oB  out  32  to adder iB.
- oOp  out  2  to adder iOp; 00 = idle.
- iF  in  32  from adder oF.
- iDone  in  1  from adder oDone pulse.

Behaviour:
- Reset: asynchronous on resetn low. State=IDLE, round-robin pointer=N_REQ-1, timeout counter=0. All registered outputs are 0: oA, oB, oOp, oRspValid, oRspId, oRspF, oRspErr. oReqReady is 0 while resetn is low.
- States:
  - IDLE: winner = first k with iReqValid[k]=1, searching from pointer+1 with wrap. oReqReady[winner]=1, combinational from iReqValid, IDLE only. On the accept edge (valid & ready): capture A, B, op, ID; pointer=winner. Legal op -> ISSUE. Op 00 or 11 -> RESP with err=1, F=32'h7FC00000; the adder is not touched.
  - ISSUE: drive oA/oB with the captured operands and oOp with the captured op for exactly one cycle -> WAIT.
  - WAIT: oOp=00; oA/oB stay held. On iDone=1: register iF into oRspF, err=0 -> RESP.
  - RESP: oRspValid=1 with oRspId/oRspF/oRspErr stable. On iRspReady=1 -> IDLE with oRspValid=0 next cycle.
- Timing: a legal request accepted at edge T has oOp nonzero during cycle T+1. The response becomes valid on the cycle after the iDone edge.
- Throughput: accept-to-accept minimum is 4 cycles, given a 1-cycle adder, iRspReady=1 and back-to-back requesters.
- No grant is issued while in ISSUE, WAIT or RESP. Requesters must hold valid and data stable until ready.
- iDone outside WAIT is ignored.
- Request validity: changes to iReqValid outside IDLE have no effect.
- Only a single request is in flight; iF is sampled only on the iDone cycle.
- Reset mid-operation: aborts immediately with no response. A late iDone after reset is ignored.

Optional Feature:
- Macro FP_ARB_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without iDone: go to RESP with err=1, F=32'h7FC00000.
  - If iDone and expiry fall on the same cycle, iDone wins (err=0).
- Not defined: counter logic is absent and WAIT is held indefinitely until iDone.

Test Plan:
- Single request: requester 0 sends A=32'h41480000, B=32'h41080000, op=01; model done 3 cycles after op. Required: oOp=01 for exactly 1 cycle, then oRspValid with Id=0, F=32'h41A80000, Err=0.
- All 4 requesters valid from reset, each sending a distinct op, iRspReady=1. Required: grant order 0,1,2,3. Then requesters 0 and 2 re-request: order 0 then 2. Each oOp pulse starts ≥4 cycles after the previous one.
- Requester 1 sends op=11. Required: oOp stays 00; response Id=1, Err=1, F=32'h7FC00000, valid the cycle after accept.
- Hold iRspReady=0 for 5 cycles during RESP with requester 3 valid. Required: oRspValid/F/Id stable, oReqReady=0. Requester 3 is granted the cycle after iRspReady rises.
- Assert resetn=0 during WAIT, then model asserts iDone 2 cycles after release. Required: all outputs 0, no response, next request handled normally.
- With FP_ARB_TIMEOUT_EN and TIMEOUT=16, the model never asserts done. Required: response Err=1, F=32'h7FC00000, 16 cycles after entering WAIT. Without the macro: no response after 200 cycles.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one multi-cycle FP adder; define FP_ARB_TIMEOUT_EN to abort a stuck WAIT
module fp_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     iReqValid,
    input  logic [32*N_REQ-1:0]  iReqA,
    input  logic [32*N_REQ-1:0]  iReqB,
    input  logic [2*N_REQ-1:0]   iReqOp,
    output logic [N_REQ-1:0]     oReqReady,
    output logic                 oRspValid,
    output logic [ID_W-1:0]      oRspId,
    output logic [31:0]          oRspF,
    output logic                 oRspErr,
    input  logic                 iRspReady,
    output logic [31:0]          oA,
    output logic [31:0]          oB,
    output logic [1:0]           oOp,
    input  logic [31:0]          iF,
    input  logic                 iDone
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            win_vld;
    logic [1:0]      win_op;
    logic            win_legal;
`ifdef FP_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
`endif

    if ((2 ** ID_W) < N_REQ || (2 ** CNT_W) <= TIMEOUT || N_REQ < 2 || N_REQ > 8) begin : g_bad_params
        $error("fp_add_arbiter: inconsistent N_REQ/ID_W/TIMEOUT/CNT_W");
    end

    // round-robin winner: first valid requester after the last one granted, with wrap
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (iReqValid[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign win_op    = iReqOp[2*win +: 2];
    assign win_legal = (win_op == 2'b01) || (win_op == 2'b10);
    assign oReqReady = (resetn && state_q == IDLE && win_vld) ? (N_REQ'(1) << win) : '0;

    // one operation in flight: accept, strobe the adder once, wait for done, hold the response until taken
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ptr_q     <= ID_W'(N_REQ - 1);
            oA        <= '0;
            oB        <= '0;
            oOp       <= '0;
            oRspValid <= 1'b0;
            oRspId    <= '0;
            oRspF     <= '0;
            oRspErr   <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (win_vld) begin
                    ptr_q  <= win;
                    oRspId <= win;
                    if (win_legal) begin
                        oA      <= iReqA[32*win +: 32];
                        oB      <= iReqB[32*win +: 32];
                        oOp     <= win_op;
                        state_q <= ISSUE;
                    end else begin
                        oRspValid <= 1'b1;
                        oRspErr   <= 1'b1;
                        oRspF     <= QNAN;
                        state_q   <= RESP;
                    end
                end
                ISSUE: begin
                    oOp     <= 2'b00;
                    state_q <= WAIT;
`ifdef FP_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: if (iDone) begin
                    oRspF     <= iF;
                    oRspErr   <= 1'b0;
                    oRspValid <= 1'b1;
                    state_q   <= RESP;
                end
`ifdef FP_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    oRspF     <= QNAN;
                    oRspErr   <= 1'b1;
                    oRspValid <= 1'b1;
                    state_q   <= RESP;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
`endif
                RESP: if (iRspReady) begin
                    oRspValid <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: scoreboard bench with a transaction-level arbiter model and a behavioural adder
module tb_fp_add_arbiter;
    localparam int N = 4;
    localparam int IW = 2;
    localparam int TO = 16;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [N-1:0]     iReqValid = '0;
    logic [32*N-1:0]  iReqA = '0;
    logic [32*N-1:0]  iReqB = '0;
    logic [2*N-1:0]   iReqOp = '0;
    logic [N-1:0]     oReqReady;
    logic             oRspValid;
    logic [IW-1:0]    oRspId;
    logic [31:0]      oRspF;
    logic             oRspErr;
    logic             iRspReady = 1'b1;
    logic [31:0]      oA, oB;
    logic [1:0]       oOp;
    logic [31:0]      iF = '0;
    logic             iDone = 1'b0;

    typedef struct packed { logic [IW-1:0] id; logic [31:0] f; logic err; } rsp_t;
    typedef struct packed { logic [31:0] a; logic [31:0] b; logic [1:0] op; } op_t;

    rsp_t sb[$];
    op_t  opq[$];
    int   grants[$];
    int   errors = 0;
    int   checks = 0;
    int   last = N - 1;
    bit   busy = 1'b0;
    bit   rand_rdy = 1'b0;
    bit   adder_hang = 1'b0;
    int   adder_lat = 1;
    int   cyc = 0;

    // free-running clock
    always #5 clk = ~clk;

    fp_add_arbiter #(.N_REQ(N), .ID_W(IW), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn), .iReqValid(iReqValid), .iReqA(iReqA), .iReqB(iReqB),
        .iReqOp(iReqOp), .oReqReady(oReqReady), .oRspValid(oRspValid), .oRspId(oRspId),
        .oRspF(oRspF), .oRspErr(oRspErr), .iRspReady(iRspReady), .oA(oA), .oB(oB),
        .oOp(oOp), .iF(iF), .iDone(iDone)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        if (f[30:0] == 31'd0) return 0.0;
        return $bitstoreal({f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        return r2f(op == 2'b01 ? f2r(a) + f2r(b) : f2r(a) - f2r(b));
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'(125 + $urandom_range(0, 7)), 10'($urandom), 13'd0};
    endfunction

    task automatic post(input int k, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        iReqValid[k] = 1'b1;
        iReqA[32*k +: 32] = a;
        iReqB[32*k +: 32] = b;
        iReqOp[2*k +: 2] = op;
    endtask

    // one clock of the requester side: model the grant, log accepts into the scoreboard, then drive
    task automatic cycle();
        logic [N-1:0] acc, exp_rdy;
        int w;
        logic [1:0] op;
        logic [31:0] a, b;
        @(negedge clk);
        acc = '0;
        exp_rdy = '0;
        w = -1;
        if (resetn) begin
            if (!busy)
                for (int i = N; i >= 1; i--)
                    if (iReqValid[(last + i) % N]) w = (last + i) % N;
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("grant", 32'(oReqReady), 32'(exp_rdy));
            if (w >= 0 && oReqReady == exp_rdy) begin
                grants.push_back(w);
                last = w;
                busy = 1'b1;
                acc = exp_rdy;
                op = iReqOp[2*w +: 2];
                a = iReqA[32*w +: 32];
                b = iReqB[32*w +: 32];
                if (op == 2'b01 || op == 2'b10) begin
                    opq.push_back('{a: a, b: b, op: op});
                    if (!adder_hang) sb.push_back('{id: IW'(w), f: fadd(a, b, op), err: 1'b0});
`ifdef FP_ARB_TIMEOUT_EN
                    else sb.push_back('{id: IW'(w), f: QNAN, err: 1'b1});
`endif
                end else begin
                    sb.push_back('{id: IW'(w), f: QNAN, err: 1'b1});
                end
            end
            if (oRspValid && iRspReady) busy = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        iReqValid = iReqValid & ~acc;
        if (rand_rdy) iRspReady = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        sb.delete();
        opq.delete();
        busy = 1'b0;
        last = N - 1;
        repeat (n) cycle();
        chk("reset_outputs_zero", 32'({oA, oB, oOp, oRspValid, oRspId, oRspF, oRspErr, oReqReady} != 0), 32'd0);
        resetn = 1'b1;
    endtask

    task automatic wait_grant(input int k, input string nm);
        int n0, t;
        n0 = grants.size();
        t = 0;
        while (grants.size() == n0 && t < 50) begin
            cycle();
            t++;
        end
        chk(nm, grants.size() > n0 ? 32'(grants[grants.size()-1]) : 32'hFFFFFFFF, 32'(k));
    endtask

    task automatic drain(input int bound);
        int t;
        t = 0;
        while ((busy || iReqValid != '0 || sb.size() != 0) && t < bound) begin
            cycle();
            t++;
        end
        chk("drain_in_time", 32'(t < bound), 32'd1);
    endtask

    // behavioural adder: checks each strobe against the accepted request and answers after adder_lat cycles
    initial begin
        int cd, last_op;
        logic [31:0] res;
        logic prev;
        op_t e;
        cd = 0;
        last_op = -100;
        res = '0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && oOp != 2'b00) begin
                chk("op_single_cycle", 32'(prev), 32'd0);
                chk("op_spacing_ge4", 32'(cyc - last_op >= 4), 32'd1);
                last_op = cyc;
                if (opq.size() == 0) begin
                    chk("op_unexpected", 32'(oOp), 32'd0);
                end else begin
                    e = opq.pop_front();
                    chk("op_a", oA, e.a);
                    chk("op_b", oB, e.b);
                    chk("op_code", 32'(oOp), 32'(e.op));
                end
                if (!adder_hang) begin
                    cd = adder_lat;
                    res = fadd(oA, oB, oOp);
                end
            end
            prev = resetn && (oOp != 2'b00);
            @(posedge clk);
            #1;
            iDone = 1'b0;
            iF = $urandom;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    iDone = 1'b1;
                    iF = res;
                end
            end
        end
    end

    // response monitor: pops the scoreboard on every handshake and checks stability while stalled
    initial begin
        rsp_t e, p;
        bit pv;
        pv = 1'b0;
        p = '0;
        forever begin
            @(negedge clk);
            if (resetn && oRspValid) begin
                if (pv) chk("rsp_stable_stall", 32'({oRspId, oRspF, oRspErr} != p), 32'd0);
                if (iRspReady) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 32'(oRspValid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", 32'(oRspId), 32'(e.id));
                        chk("rsp_f", oRspF, e.f);
                        chk("rsp_err", 32'(oRspErr), 32'(e.err));
                    end
                end
            end
            pv = resetn && oRspValid && !iRspReady;
            p = {oRspId, oRspF, oRspErr};
        end
    end

    // directed scenarios followed by randomized traffic
    initial begin
        int n, g0;
        bit seen;
        do_reset(3);
        adder_lat = 3;
        post(0, 32'h41480000, 32'h41080000, 2'b01);
        wait_grant(0, "single_grant");
        chk("single_expected_sum", fadd(32'h41480000, 32'h41080000, 2'b01), 32'h41A80000);
        drain(40);

        adder_lat = 1;
        resetn = 1'b0;
        for (int k = 0; k < N; k++) post(k, rnd_f(), rnd_f(), 2'(1 + k % 2));
        do_reset(2);
        g0 = grants.size();
        drain(100);
        for (int k = 0; k < N; k++) chk("rr_order_all", 32'(grants[g0 + k]), 32'(k));
        post(0, rnd_f(), rnd_f(), 2'b10);
        post(2, rnd_f(), rnd_f(), 2'b01);
        g0 = grants.size();
        drain(100);
        chk("rr_order_0", 32'(grants[g0]), 32'd0);
        chk("rr_order_2", 32'(grants[g0 + 1]), 32'd2);

        post(1, rnd_f(), rnd_f(), 2'b11);
        wait_grant(1, "illegal_grant");
        chk("illegal_rsp_next_cycle", 32'(oRspValid), 32'd1);
        drain(20);

        iRspReady = 1'b0;
        post(0, rnd_f(), rnd_f(), 2'b01);
        wait_grant(0, "stall_first_grant");
        post(3, rnd_f(), rnd_f(), 2'b10);
        n = 0;
        while (!oRspValid && n < 20) begin cycle(); n++; end
        repeat (5) cycle();
        iRspReady = 1'b1;
        cycle();
        g0 = grants.size();
        cycle();
        chk("stall_then_grant3", grants.size() > g0 ? 32'(grants[g0]) : 32'hFFFFFFFF, 32'd3);
        drain(40);

        adder_lat = 6;
        post(2, rnd_f(), rnd_f(), 2'b01);
        wait_grant(2, "abort_grant");
        repeat (2) cycle();
        post(1, rnd_f(), rnd_f(), 2'b10);
        do_reset(2);
        wait_grant(1, "post_reset_grant");
        repeat (3) cycle();
        adder_lat = 2;
        drain(40);

        adder_hang = 1'b1;
        post(3, rnd_f(), rnd_f(), 2'b01);
        wait_grant(3, "hang_grant");
        cycle();
        n = 0;
        seen = 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
        while (!oRspValid && n < 100) begin cycle(); n++; end
        chk("timeout_cycles", 32'(n), 32'(TO));
        drain(20);
        adder_hang = 1'b0;
`else
        repeat (200) begin cycle(); seen |= oRspValid; end
        chk("hang_no_rsp", 32'(seen), 32'd0);
        adder_hang = 1'b0;
        do_reset(2);
`endif

        rand_rdy = 1'b1;
        for (int it = 0; it < 400; it++) begin
            if (it % 25 == 0) adder_lat = $urandom_range(1, 4);
            for (int k = 0; k < N; k++)
                if (!iReqValid[k] && $urandom_range(0, 5) == 0)
                    post(k, rnd_f(), rnd_f(), ($urandom_range(0, 9) == 0) ? 2'(3 * $urandom_range(0, 1)) : 2'(1 + $urandom_range(0, 1)));
            cycle();
        end
        rand_rdy = 1'b0;
        iRspReady = 1'b1;
        drain(300);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("op_queue_empty", 32'(opq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
